// File: rtl/data_buffer_pkg.sv
// data_buffer_pkg: shared definitions for the buffer controller and the FIFO.
//   op_t          - operation code driven by the controller (NOP/WRITE/READ)
//   BUFFER_DEPTH  - number of stored bytes
//   PTR_WIDTH     - pointer width (address bits plus one wrap bit)
package data_buffer_pkg;

  localparam int BUFFER_DEPTH = 64;
  localparam int PTR_WIDTH    = 7;
  localparam int ADDR_WIDTH   = PTR_WIDTH - 1;
  localparam int DATA_WIDTH   = 8;

  // 2'b11 is unused and decodes as NOP in the FIFO.
  typedef enum logic [1:0] {
    NOP   = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10
  } op_t;

endpackage

// File: rtl/fifo_pointer.sv
// fifo_pointer: PTR_WIDTH-bit wrapping counter used for the FIFO write and read
// pointers.
//   clk    - clock
//   rst    - asynchronous active-high reset, pointer -> 0
//   clr_i  - synchronous clear, wins over en_i
//   en_i   - advance pointer by one (wraps at 2**PTR_WIDTH)
//   ptr_o  - current pointer value
module fifo_pointer
  import data_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic [PTR_WIDTH-1:0] ptr_o
);

  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)     ptr_d = '0;
    else if (en_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/data_buffer_fifo.sv
// data_buffer_fifo: 64 x 8-bit first-word-fall-through FIFO with flush and
// sticky overflow/underflow flags.
//   clk, rst            - clock, asynchronous active-high reset
//   op                  - NOP/WRITE/READ (2'b11 acts as NOP)
//   write_data          - byte stored on a qualified WRITE
//   write_count_enable  - qualifies WRITE
//   read_count_enable   - qualifies READ
//   empty_buffer        - flush: clears pointers and error flags, beats op
//   read_data           - head byte, combinational, 8'h00 when empty
//   buffer_occupancy    - stored byte count 0..64
//   full, empty         - occupancy == 64 / == 0
//   overflow_err        - sticky: qualified WRITE attempted while full
//   underflow_err       - sticky: qualified READ attempted while empty
module data_buffer_fifo
  import data_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_count_enable,
  input  logic                  read_count_enable,
  input  logic                  empty_buffer,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [PTR_WIDTH-1:0]  buffer_occupancy,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  op_t                  op_e;
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                 wr_req, rd_req, wr_en, rd_en;
  logic                 ovf_q, ovf_d, udf_q, udf_d;
  logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];

  assign op_e = op_t'(op);

  // Qualified requests; flush masks them entirely.
  assign wr_req = !empty_buffer && (op_e == WRITE) && write_count_enable;
  assign rd_req = !empty_buffer && (op_e == READ)  && read_count_enable;
  assign wr_en  = wr_req && !full;
  assign rd_en  = rd_req && !empty;

  fifo_pointer u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (empty_buffer),
    .en_i  (wr_en),
    .ptr_o (wr_ptr)
  );

  fifo_pointer u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (empty_buffer),
    .en_i  (rd_en),
    .ptr_o (rd_ptr)
  );

  // Storage is not reset; the rst term keeps a write coincident with reset
  // from landing in the array.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr[ADDR_WIDTH-1:0]] <= write_data;
  end

  assign buffer_occupancy = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[PTR_WIDTH-1] != rd_ptr[PTR_WIDTH-1]);

  // Gating on empty hides uninitialised array contents.
  assign read_data = empty ? '0 : mem_q[rd_ptr[ADDR_WIDTH-1:0]];

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (empty_buffer) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (wr_req && full)  ovf_d = 1'b1;
      if (rd_req && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;

endmodule

// File: doc/data_buffer_fifo.md
DATA_BUFFER_FIFO -- requirements
Module: data_buffer_fifo

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; clock and reset ports listed first.
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port: op  input  2  operation code from buffer controller, NOP/WRITE/READ (package encoding).
REQ-005 SHALL have port: write_data  input  8  byte to store on WRITE.
REQ-006 SHALL have port: write_count_enable  input  1  qualifies WRITE; write pointer advances only when set.
REQ-007 SHALL have port: read_count_enable  input  1  qualifies READ; read pointer advances only when set.
REQ-008 SHALL have port: empty_buffer  input  1  flush/clear request.
REQ-009 SHALL have port: read_data  output  8  head-of-FIFO byte, first-word-fall-through.
REQ-010 SHALL have port: buffer_occupancy  output  7  stored byte count, 0..64.
REQ-011 SHALL have ports: full, empty  output  1 each  occupancy==64, occupancy==0.
REQ-012 SHALL have ports: overflow_err, underflow_err  output  1 each  sticky error flags.

Function
REQ-013 SHALL store 64 bytes; write/read pointers 7 bits (6-bit address plus wrap bit).
REQ-014 Write: when op==WRITE and write_count_enable and not full, SHALL store write_data at wr_ptr[5:0] and increment wr_ptr on the same edge.
REQ-015 Read: read_data SHALL be combinational mem[rd_ptr[5:0]], zero latency; when op==READ and read_count_enable and not empty, rd_ptr SHALL increment on the edge.
REQ-016 read_data SHALL be 8'h00 whenever empty==1.
REQ-017 op==WRITE or READ without the matching count enable SHALL cause no state change; op==2'b11 SHALL be treated as NOP.
REQ-018 buffer_occupancy SHALL be wr_ptr minus rd_ptr modulo 128; full when wr_ptr[5:0]==rd_ptr[5:0] and wrap bits differ; empty when pointers equal.
REQ-019 Pointers SHALL wrap 127->0 without disturbing occupancy.
REQ-020 WRITE when full SHALL be dropped (no pointer or memory change) and SHALL set overflow_err.
REQ-021 READ when empty SHALL leave rd_ptr unchanged and SHALL set underflow_err.
REQ-022 empty_buffer SHALL take priority over op: on the edge, both pointers and both error flags cleared to 0; memory contents unchanged.
REQ-023 Error flags SHALL remain set until empty_buffer or rst.
REQ-024 Flags and occupancy SHALL reflect an operation in the cycle after its edge.

Reset
REQ-025 On rst==1 (asynchronous), wr_ptr=0, rd_ptr=0, buffer_occupancy=0, empty=1, full=0, overflow_err=0, underflow_err=0, read_data=8'h00.
REQ-026 Memory array SHALL not be reset; REQ-016 guarantees deterministic read_data.
REQ-027 rst asserted mid-operation SHALL abort any pending write; first post-reset edge behaves as from empty.

Structure
REQ-028 Shared package data_buffer_pkg SHALL hold op_type enum (NOP=2'b00, WRITE=2'b01, READ=2'b10), BUFFER_DEPTH=64, PTR_WIDTH=7; controller and FIFO both import it.
REQ-029 Pointer logic SHALL be one sub-module fifo_pointer (7-bit counter, enable, synchronous clear, async reset), instantiated for write and read pointers.
REQ-030 Storage SHALL be a flop array inside data_buffer_fifo; no vendor RAM macro.

Verification
REQ-031 Reset then write 8'hA5, 8'h3C -> occupancy 2, read_data 8'hA5; one READ -> read_data 8'h3C, occupancy 1.
REQ-032 64 writes of 0..63 -> full=1, occupancy 64; 65th write 8'hFF dropped, overflow_err=1; 64 reads return 0..63 in order.
REQ-033 READ on empty buffer -> underflow_err=1, read_data 8'h00, occupancy 0.
REQ-034 Fill 40, read 40, write 40 more (pointer wrap past 63) -> data in order, occupancy tracks 40->0->40.
REQ-035 Occupancy 10 with empty_buffer and op=WRITE same cycle -> occupancy 0, empty=1, no write, error flags cleared.
REQ-036 rst asserted asynchronously mid-cycle with occupancy 5 -> outputs at reset values immediately, before next clk edge.
